// File: rtl/alu_result_buffer.sv
// Result FIFO between the 64-bit ALU and writeback, with sticky flags and an accepted-op counter.
// Define ALU_RESBUF_PARITY_EN to store even parity per entry and expose out_parity_err.
module alu_result_buffer #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [3:0]                in_opcode,
   input  logic [WIDTH-1:0]          in_result,
   input  logic                      in_carry,
   input  logic                      in_zero,
   input  logic                      in_overflow,
   input  logic                      in_sign,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [3:0]                out_opcode,
   output logic [WIDTH-1:0]          out_result,
   output logic [3:0]                out_flags,
   output logic [3:0]                sticky_flags,
   input  logic                      sticky_clr,
   output logic [CNT_W-1:0]          op_count,
   output logic [$clog2(DEPTH):0]    level
`ifdef ALU_RESBUF_PARITY_EN
   ,
   output logic                      out_parity_err
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int EW = WIDTH + 8;
   localparam logic [PW-1:0]    PTR_ONE = 1;
   localparam logic [PW:0]      LVL_ONE = 1;
   localparam logic [PW:0]      LVL_FULL = DEPTH[PW:0];
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   logic [EW-1:0]    mem_q [DEPTH];
   logic [EW-1:0]    mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW:0]      level_q, level_d;
   logic [CNT_W-1:0] op_count_q, op_count_d;
   logic [3:0]       sticky_q, sticky_d;

   logic [3:0]       in_flags;
   logic [EW-1:0]    in_entry;
   logic [EW-1:0]    head;
   logic             full;
   logic             push;
   logic             pop;

   assign in_flags  = {in_sign, in_overflow, in_zero, in_carry};
   assign in_entry  = {in_opcode, in_result, in_flags};
   assign full      = (level_q == LVL_FULL);
   // in_ready also drops while reset is held so no handshake can complete during it
   assign in_ready  = rst_n & ~full;
   assign out_valid = (level_q != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   assign head       = mem_q[rd_ptr_q];
   assign out_opcode = head[EW-1 -: 4];
   assign out_result = head[WIDTH+3:4];
   assign out_flags  = head[3:0];

   assign sticky_flags = sticky_q;
   assign op_count     = op_count_q;
   assign level        = level_q;

   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      op_count_d = op_count_q;
      sticky_d   = sticky_clr ? 4'b0000 : sticky_q;

      if (push) begin
         mem_d[wr_ptr_q] = in_entry;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
         op_count_d      = op_count_q + CNT_ONE;
         sticky_d        = sticky_d | in_flags;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end

      case ({push, pop})
         2'b10:   level_d = level_q + LVL_ONE;
         2'b01:   level_d = level_q - LVL_ONE;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         op_count_q <= '0;
         sticky_q   <= '0;
      end else begin
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         op_count_q <= op_count_d;
         sticky_q   <= sticky_d;
      end
   end

`ifdef ALU_RESBUF_PARITY_EN
   logic [DEPTH-1:0] par_q, par_d;

   always_comb begin
      par_d = par_q;
      if (push) begin
         par_d[wr_ptr_q] = ^in_entry;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_q <= '0;
      end else begin
         par_q <= par_d;
      end
   end

   assign out_parity_err = out_valid & ((^head) != par_q[rd_ptr_q]);
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed self-checking bench for alu_result_buffer using a scoreboard queue of expected entries.
// Parity checks are compiled in when ALU_RESBUF_PARITY_EN is defined.
module tb_alu_result_buffer;

   localparam int WIDTH = 64;
   localparam int DEPTH = 4;
   localparam int CNT_W = 16;

   typedef struct packed {
      logic [3:0]       op;
      logic [WIDTH-1:0] res;
      logic [3:0]       fl;
   } entry_t;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       in_opcode;
   logic [WIDTH-1:0] in_result;
   logic             in_carry;
   logic             in_zero;
   logic             in_overflow;
   logic             in_sign;
   logic             out_valid;
   logic             out_ready;
   logic [3:0]       out_opcode;
   logic [WIDTH-1:0] out_result;
   logic [3:0]       out_flags;
   logic [3:0]       sticky_flags;
   logic             sticky_clr;
   logic [CNT_W-1:0] op_count;
   logic [2:0]       level;
`ifdef ALU_RESBUF_PARITY_EN
   logic             out_parity_err;
   logic [DEPTH-1:0] par_snap;
`endif

   entry_t           sb[$];
   logic [CNT_W-1:0] model_count;
   logic [3:0]       model_sticky;
   int               checks;
   int               errors;
   bit               skip_perr;

   alu_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_opcode    (in_opcode),
      .in_result    (in_result),
      .in_carry     (in_carry),
      .in_zero      (in_zero),
      .in_overflow  (in_overflow),
      .in_sign      (in_sign),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_opcode   (out_opcode),
      .out_result   (out_result),
      .out_flags    (out_flags),
      .sticky_flags (sticky_flags),
      .sticky_clr   (sticky_clr),
      .op_count     (op_count),
      .level        (level)
`ifdef ALU_RESBUF_PARITY_EN
      ,
      .out_parity_err (out_parity_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Called at a falling edge; evaluates the handshake just before the rising edge, then returns at the next falling edge.
   task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [63:0] res,
                                input logic [3:0] fl, input logic rdy, input logic clr);
      entry_t e;
      bit     do_push;
      bit     do_pop;
      in_valid  = v;
      in_opcode = op;
      in_result = res;
      {in_sign, in_overflow, in_zero, in_carry} = fl;
      out_ready  = rdy;
      sticky_clr = clr;
      #4;
      do_push = v && (sb.size() != DEPTH);
      do_pop  = rdy && (sb.size() != 0);
      checkOutput("in_ready", in_ready, sb.size() != DEPTH);
      checkOutput("out_valid", out_valid, sb.size() != 0);
`ifdef ALU_RESBUF_PARITY_EN
      if (!skip_perr) checkOutput("parity_err_clean", out_parity_err, 0);
`endif
      if (do_pop) begin
         e = sb.pop_front();
         checkOutput("out_opcode", out_opcode, e.op);
         checkOutput("out_result", out_result, e.res);
         checkOutput("out_flags", out_flags, e.fl);
      end
      if (do_push) begin
         e.op  = op;
         e.res = res;
         e.fl  = fl;
         sb.push_back(e);
         model_count = model_count + 1'b1;
      end
      if (clr) model_sticky = 4'b0000;
      if (do_push) model_sticky = model_sticky | fl;
      @(posedge clk);
      @(negedge clk);
      checkOutput("level", level, sb.size());
      checkOutput("op_count", op_count, model_count);
      checkOutput("sticky_flags", sticky_flags, model_sticky);
   endtask

   task automatic drain();
      while (sb.size() != 0) applyStimulus(1'b0, 4'h0, 64'h0, 4'h0, 1'b1, 1'b0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      skip_perr = 1'b0;
      model_count = '0;
      model_sticky = '0;
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_opcode = '0;
      in_result = '0;
      {in_sign, in_overflow, in_zero, in_carry} = 4'b0000;
      out_ready = 1'b0;
      sticky_clr = 1'b0;

      @(negedge clk);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_in_ready_low", in_ready, 0);
      checkOutput("rst_level", level, 0);
      checkOutput("rst_op_count", op_count, 0);
      checkOutput("rst_sticky", sticky_flags, 0);
      checkOutput("rst_out_result", out_result, 0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rel_in_ready", in_ready, 1);

      // Single push into an empty buffer, consumer stalled
      applyStimulus(1'b1, 4'd4, 64'h6, 4'b0000, 1'b0, 1'b0);
      checkOutput("first_out_valid", out_valid, 1);
      checkOutput("first_out_result", out_result, 64'h6);
      checkOutput("first_out_flags", out_flags, 4'b0000);
      checkOutput("first_level", level, 1);
      checkOutput("first_op_count", op_count, 1);
      drain();

      // Fill to full, hold a fifth request, then release the consumer
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b1, 4'(i + 1), 64'h100 + 64'(i), 4'(i), 1'b0, 1'b0);
      checkOutput("full_level", level, 4);
      checkOutput("full_in_ready", in_ready, 0);
      applyStimulus(1'b1, 4'd5, 64'h555, 4'b0100, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'd5, 64'h555, 4'b0100, 1'b0, 1'b0);
      checkOutput("held_op_count", op_count, 5);
      applyStimulus(1'b1, 4'd5, 64'h555, 4'b0100, 1'b1, 1'b0);
      checkOutput("in_ready_after_pop", in_ready, 1);
      applyStimulus(1'b1, 4'd5, 64'h555, 4'b0100, 1'b1, 1'b0);
      checkOutput("late_op_count", op_count, 6);
      drain();

      // Streaming at level 2 across several pointer wraps
      applyStimulus(1'b1, 4'd7, 64'd100, 4'b0000, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'd7, 64'd101, 4'b0000, 1'b0, 1'b0);
      for (int i = 1; i <= 10; i++)
         applyStimulus(1'b1, 4'd8, 64'(i), 4'b0000, 1'b1, 1'b0);
      checkOutput("stream_level", level, 2);
      checkOutput("stream_op_count", op_count, 18);
      drain();

      // Sticky accumulation and clear-with-push
      applyStimulus(1'b0, 4'd0, 64'h0, 4'b0000, 1'b1, 1'b1);
      checkOutput("sticky_cleared", sticky_flags, 4'b0000);
      applyStimulus(1'b1, 4'd2, 64'h8000_0000_0000_0000, 4'b1000, 1'b1, 1'b0);
      applyStimulus(1'b1, 4'd2, 64'h0, 4'b0010, 1'b1, 1'b0);
      checkOutput("sticky_sign_zero", sticky_flags, 4'b1010);
      applyStimulus(1'b1, 4'd1, 64'h3, 4'b0001, 1'b1, 1'b1);
      checkOutput("sticky_clr_push", sticky_flags, 4'b0001);
      drain();

      // Async reset in the middle of traffic
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b1, 4'd3, 64'hA0 + 64'(i), 4'b0110, 1'b0, 1'b0);
      checkOutput("pre_reset_level", level, 3);
      rst_n = 1'b0;
      in_valid = 1'b1;
      #1;
      checkOutput("midrst_out_valid", out_valid, 0);
      checkOutput("midrst_level", level, 0);
      checkOutput("midrst_op_count", op_count, 0);
      checkOutput("midrst_sticky", sticky_flags, 0);
      checkOutput("midrst_in_ready", in_ready, 0);
      sb.delete();
      model_count = '0;
      model_sticky = '0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("held_rst_level", level, 0);
      in_valid = 1'b0;
      rst_n = 1'b1;
      #1;
      checkOutput("post_rst_in_ready", in_ready, 1);
      checkOutput("post_rst_out_valid", out_valid, 0);
      @(negedge clk);

      // First entry after reset sits in slot 0
      applyStimulus(1'b1, 4'h9, 64'h1234, 4'b0101, 1'b0, 1'b0);
`ifdef ALU_RESBUF_PARITY_EN
      #1;
      checkOutput("parity_good_head", out_parity_err, 0);
      par_snap = dut.par_q;
      force dut.par_q = par_snap ^ 4'b0001;
      #1;
      checkOutput("parity_flip_head", out_parity_err, 1);
      release dut.par_q;
      skip_perr = 1'b1;
      @(negedge clk);
      applyStimulus(1'b0, 4'h0, 64'h0, 4'h0, 1'b1, 1'b0);
      skip_perr = 1'b0;
`endif
      applyStimulus(1'b1, 4'hC, 64'hDEAD_BEEF, 4'b1111, 1'b1, 1'b0);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
